fir_coef_reload_ctrl: RTL and testbench



---
 rtl/fir_coef_reload_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fir_coef_reload_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_reload_ctrl.sv
// Coefficient reload sequencer for a transposed FIR: shadow-bank loading, atomic bank swap,
// zero-flush of the filter pipeline after each swap, and sample forwarding to the filter.
`timescale 1ns/1ps
module fir_coef_reload_ctrl #(
  parameter int DATA_WIDTH = 24,
  parameter int FIR_DEPTH  = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [DATA_WIDTH-1:0]            iv_din,
  input  logic                             i_din_valid,
  output logic                             o_din_ready,
  input  logic [DATA_WIDTH-1:0]            iv_coef,
  input  logic                             i_coef_valid,
  input  logic                             i_coef_last,
  output logic                             o_coef_ready,
  input  logic                             i_flush_req,
  output logic [DATA_WIDTH-1:0]            ov_fir_din,
  output logic                             o_fir_din_valid,
  output logic [FIR_DEPTH*DATA_WIDTH-1:0]  ov_weights,
  output logic                             o_dout_gate,
  output logic                             o_busy,
  output logic                             o_load_err
);

  localparam int CNT_W = (FIR_DEPTH > 1) ? $clog2(FIR_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FIR_DEPTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  logic [1:0]            state_reg, state_next;
  logic [CNT_W-1:0]      coef_cnt_reg, coef_cnt_next;
  logic [CNT_W-1:0]      flush_cnt_reg, flush_cnt_next;
  logic [DATA_WIDTH-1:0] fir_din_reg;
  logic                  fir_din_valid_reg;
  logic                  flush_out_reg;
  logic                  dout_gate_reg, dout_gate_next;
  logic                  load_err_reg;

  logic in_flush;
  logic din_fire;
  logic coef_fire;
  logic cnt_at_end;
  logic load_done;
  logic load_bad;

  assign in_flush   = (state_reg == FLUSH);
  assign din_fire   = i_din_valid & ~in_flush;
  assign coef_fire  = i_coef_valid & ~in_flush;
  assign cnt_at_end = (coef_cnt_reg == LAST_IDX);
  assign load_done  = coef_fire & i_coef_last & cnt_at_end;
  // Early last and overrun (full bank without last) are the same malformed-load case.
  assign load_bad   = coef_fire & (i_coef_last ^ cnt_at_end);

  always_comb begin
    state_next     = state_reg;
    coef_cnt_next  = coef_cnt_reg;
    flush_cnt_next = '0;
    case (state_reg)
      IDLE: begin
        // A coefficient handshake takes precedence over a flush request in the same cycle.
        if (coef_fire) begin
          if (load_done)     state_next = FLUSH;
          else if (load_bad) state_next = IDLE;
          else               state_next = LOAD;
        end else if (i_flush_req) begin
          state_next = FLUSH;
        end
      end
      LOAD: begin
        if (load_done)     state_next = FLUSH;
        else if (load_bad) state_next = IDLE;
        else               state_next = LOAD;
      end
      FLUSH: begin
        if (flush_cnt_reg == LAST_IDX) begin
          state_next = IDLE;
        end else begin
          flush_cnt_next = flush_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (coef_fire) begin
      if (load_done || load_bad) coef_cnt_next = '0;
      else                       coef_cnt_next = coef_cnt_reg + 1'b1;
    end
  end

  // Gate stays low while flush zeros are on the filter input and one cycle beyond,
  // covering the filter's registered output-valid stage.
  assign dout_gate_next = ~(in_flush | flush_out_reg);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      coef_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
      flush_out_reg <= 1'b0;
      dout_gate_reg <= 1'b1;
      load_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      coef_cnt_reg  <= coef_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
      flush_out_reg <= in_flush;
      dout_gate_reg <= dout_gate_next;
      load_err_reg  <= load_bad;
    end
  end

  // Flush cycles override the sample path; the swap-cycle sample is already registered by then.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fir_din_reg       <= '0;
      fir_din_valid_reg <= 1'b0;
    end else if (in_flush) begin
      fir_din_reg       <= '0;
      fir_din_valid_reg <= 1'b1;
    end else if (din_fire) begin
      fir_din_reg       <= iv_din;
      fir_din_valid_reg <= 1'b1;
    end else begin
      fir_din_valid_reg <= 1'b0;
    end
  end

  generate
    for (genvar gi = 0; gi < FIR_DEPTH; gi++) begin : tap_g
      logic [DATA_WIDTH-1:0] shadow_reg;
      logic [DATA_WIDTH-1:0] active_reg;
      logic [DATA_WIDTH-1:0] swap_word;

      // The final tap is taken straight from the bus so the swap includes the last word.
      if (gi == FIR_DEPTH - 1) begin : last_g
        assign swap_word = iv_coef;
      end else begin : mid_g
        assign swap_word = shadow_reg;
      end

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          shadow_reg <= '0;
          active_reg <= '0;
        end else begin
          if (coef_fire && (coef_cnt_reg == CNT_W'(gi))) begin
            shadow_reg <= iv_coef;
          end
          if (load_done) begin
            active_reg <= swap_word;
          end
        end
      end

      assign ov_weights[gi*DATA_WIDTH +: DATA_WIDTH] = active_reg;
    end
  endgenerate

  assign o_din_ready     = ~in_flush;
  assign o_coef_ready    = ~in_flush;
  assign o_busy          = (state_reg != IDLE);
  assign ov_fir_din      = fir_din_reg;
  assign o_fir_din_valid = fir_din_valid_reg;
  assign o_dout_gate     = dout_gate_reg;
  assign o_load_err      = load_err_reg;

endmodule

// File: tb/tb_fir_coef_reload_ctrl.sv
// Directed bench for fir_coef_reload_ctrl: forwarding, full/short/overrun loads, flush
// requests and asynchronous reset during a flush.
`timescale 1ns/1ps
module tb_fir_coef_reload_ctrl;
  localparam int DW    = 24;
  localparam int DEPTH = 16;
  localparam int WW    = DW * DEPTH;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          din_ready;
  logic [DW-1:0] coef = '0;
  logic          coef_valid = 1'b0;
  logic          coef_last = 1'b0;
  logic          coef_ready;
  logic          flush_req = 1'b0;
  logic [DW-1:0] fir_din;
  logic          fir_din_valid;
  logic [WW-1:0] weights;
  logic          dout_gate;
  logic          busy;
  logic          load_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fir_coef_reload_ctrl #(.DATA_WIDTH(DW), .FIR_DEPTH(DEPTH)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .iv_din          (din),
    .i_din_valid     (din_valid),
    .o_din_ready     (din_ready),
    .iv_coef         (coef),
    .i_coef_valid    (coef_valid),
    .i_coef_last     (coef_last),
    .o_coef_ready    (coef_ready),
    .i_flush_req     (flush_req),
    .ov_fir_din      (fir_din),
    .o_fir_din_valid (fir_din_valid),
    .ov_weights      (weights),
    .o_dout_gate     (dout_gate),
    .o_busy          (busy),
    .o_load_err      (load_err)
  );

  // Expected bank: tap k holds base+k, or all zero for base 0.
  function automatic logic [WW-1:0] bank(input int base);
    logic [WW-1:0] b;
    b = '0;
    if (base != 0) begin
      for (int k = 0; k < DEPTH; k++) b[k*DW +: DW] = DW'(base + k);
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h", tag, obs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_din_ready", din_ready, 1);
    check("rst_coef_ready", coef_ready, 1);
    check("rst_gate", dout_gate, 1);
    check("rst_busy", busy, 0);
    check("rst_err", load_err, 0);
    check("rst_valid", fir_din_valid, 0);
    check("rst_fir_din", fir_din, 0);
    check("rst_weights", weights, bank(0));
    rst = 1'b0;

    // 1: plain forwarding with one cycle of latency
    for (int i = 1; i <= 3; i++) begin
      din = DW'(i);
      din_valid = 1'b1;
      tick();
      check("t1_fir_din", fir_din, i);
      check("t1_valid", fir_din_valid, 1);
      check("t1_gate", dout_gate, 1);
    end
    din_valid = 1'b0;
    tick();
    check("t1_idle_valid", fir_din_valid, 0);
    check("t1_hold", fir_din, 3);
    check("t1_weights", weights, bank(0));

    // 2: full load with samples flowing, swap, then 16-sample flush
    for (int i = 0; i < DEPTH; i++) begin
      coef = DW'(i + 1);
      coef_valid = 1'b1;
      coef_last = (i == DEPTH - 1);
      din = DW'(100 + i);
      din_valid = 1'b1;
      tick();
      check("t2_fwd", fir_din, 100 + i);
      check("t2_fwd_valid", fir_din_valid, 1);
      if (i == 0) check("t2_busy_load", busy, 1);
    end
    check("t2_weights", weights, bank(1));
    check("t2_din_ready", din_ready, 0);
    check("t2_coef_ready", coef_ready, 0);
    check("t2_busy", busy, 1);
    check("t2_gate_swap", dout_gate, 1);
    coef_valid = 1'b0;
    coef_last = 1'b0;
    din_valid = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      tick();
      check("t2_flush_din", fir_din, 0);
      check("t2_flush_valid", fir_din_valid, 1);
      check("t2_flush_gate", dout_gate, 0);
      check("t2_flush_busy", busy, (j < DEPTH - 1) ? 1 : 0);
      check("t2_flush_ready", din_ready, (j == DEPTH - 1) ? 1 : 0);
    end
    tick();
    check("t2_post_valid", fir_din_valid, 0);
    check("t2_post_gate", dout_gate, 0);
    check("t2_post_busy", busy, 0);
    tick();
    check("t2_gate_back", dout_gate, 1);

    // 3: early last on word 5, then a good load from a restarted counter
    for (int i = 0; i < 5; i++) begin
      coef = DW'(32'h200 + i);
      coef_valid = 1'b1;
      coef_last = (i == 4);
      tick();
      if (i < 4) check("t3_err_quiet", load_err, 0);
    end
    coef_valid = 1'b0;
    coef_last = 1'b0;
    check("t3_err", load_err, 1);
    check("t3_weights", weights, bank(1));
    check("t3_busy", busy, 0);
    tick();
    check("t3_err_pulse", load_err, 0);
    check("t3_no_flush_ready", din_ready, 1);
    check("t3_no_flush_valid", fir_din_valid, 0);
    for (int i = 0; i < DEPTH; i++) begin
      coef = DW'(32'h100 + i);
      coef_valid = 1'b1;
      coef_last = (i == DEPTH - 1);
      tick();
    end
    coef_valid = 1'b0;
    coef_last = 1'b0;
    check("t3_reload_weights", weights, bank(32'h100));
    check("t3_reload_busy", busy, 1);
    for (int j = 0; j < DEPTH + 2; j++) tick();
    check("t3_done_busy", busy, 0);
    check("t3_done_gate", dout_gate, 1);

    // 4: overrun (16 words, no last)
    for (int i = 0; i < DEPTH; i++) begin
      coef = DW'(32'h300 + i);
      coef_valid = 1'b1;
      tick();
    end
    coef_valid = 1'b0;
    check("t4_err", load_err, 1);
    check("t4_weights", weights, bank(32'h100));
    check("t4_busy", busy, 0);
    tick();
    check("t4_err_pulse", load_err, 0);
    check("t4_ready", din_ready, 1);

    // 5: flush request in IDLE, re-requested mid-flush without restarting
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    check("t5_busy", busy, 1);
    check("t5_ready", din_ready, 0);
    check("t5_weights", weights, bank(32'h100));
    for (int j = 0; j < DEPTH; j++) begin
      flush_req = (j == 6);
      tick();
      check("t5_flush_din", fir_din, 0);
      check("t5_flush_valid", fir_din_valid, 1);
      check("t5_flush_busy", busy, (j < DEPTH - 1) ? 1 : 0);
    end
    flush_req = 1'b0;
    tick();
    check("t5_len_valid", fir_din_valid, 0);
    check("t5_len_gate", dout_gate, 0);
    check("t5_len_busy", busy, 0);
    tick();

    // 6: asynchronous reset at flush cycle 7
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int j = 0; j < 6; j++) tick();
    check("t6_pre_busy", busy, 1);
    check("t6_pre_weights", weights, bank(32'h100));
    #2;
    rst = 1'b1;
    #1;
    check("t6_async_ready", din_ready, 1);
    check("t6_async_coef_ready", coef_ready, 1);
    check("t6_async_busy", busy, 0);
    check("t6_async_valid", fir_din_valid, 0);
    check("t6_async_din", fir_din, 0);
    check("t6_async_gate", dout_gate, 1);
    check("t6_async_weights", weights, bank(0));
    tick();
    rst = 1'b0;
    din = DW'(7);
    din_valid = 1'b1;
    tick();
    check("t6_fwd7", fir_din, 7);
    check("t6_fwd7_valid", fir_din_valid, 1);
    din = DW'(8);
    tick();
    check("t6_fwd8", fir_din, 8);
    check("t6_weights", weights, bank(0));
    check("t6_gate", dout_gate, 1);
    din_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
